// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM period and high-time capture with loss-of-signal detect
//
// Measures an asynchronous PWM input in clk cycles, rising edge to rising edge.
//
// Parameters:
//   N            width of the cycle counter and measurement outputs
//   SYNC_STAGES  depth of the input synchronizer (2 or more)
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   ena          capture enable; low aborts any measurement and idles the block
//   pwm_in       asynchronous PWM waveform
//   period       last measured period (cycles)
//   high_time    last measured high time (cycles)
//   valid        one-cycle pulse when period/high_time update
//   no_signal    level: counter saturated without a qualifying edge
//   stuck_level  synchronized input level captured when no_signal rose
module pwm_capture #(
  parameter int N           = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         pwm_in,
  output logic [N-1:0] period,
  output logic [N-1:0] high_time,
  output logic         valid,
  output logic         no_signal,
  output logic         stuck_level
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LOW,
    WAIT_RISE,
    HIGH,
    LOW,
    STUCK
  } state_t;

  localparam logic [N-1:0] CNT_MAX = '1;
  localparam logic [N-1:0] CNT_ONE = {{(N-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_prev;
  state_t                 r_state;
  logic [N-1:0]           r_cnt;
  logic [N-1:0]           r_hi;
  logic [N-1:0]           r_period;
  logic [N-1:0]           r_high_time;
  logic                   r_valid;
  logic                   r_no_signal;
  logic                   r_stuck_level;

  logic                   w_s;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_cnt_max;
  logic [N-1:0]           w_cnt_inc;

  assign w_s       = r_sync[SYNC_STAGES-1];
  assign w_rise    = w_s & ~r_s_prev;
  assign w_fall    = ~w_s & r_s_prev;
  assign w_cnt_max = (r_cnt == CNT_MAX);
  // Saturating increment: when an edge wins at the MAX count the counter must
  // not wrap, so the following state still sees MAX and can declare STUCK.
  assign w_cnt_inc = w_cnt_max ? r_cnt : r_cnt + CNT_ONE;

  assign period      = r_period;
  assign high_time   = r_high_time;
  assign valid       = r_valid;
  assign no_signal   = r_no_signal;
  assign stuck_level = r_stuck_level;

  // Input synchronizer keeps running regardless of ena so the edge detector
  // has a settled history the moment capture is re-enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync   <= '0;
      r_s_prev <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], pwm_in};
      r_s_prev <= w_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_hi          <= '0;
      r_period      <= '0;
      r_high_time   <= '0;
      r_valid       <= 1'b0;
      r_no_signal   <= 1'b0;
      r_stuck_level <= 1'b0;
    end else if (!ena) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_valid     <= 1'b0;
      r_no_signal <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt   <= '0;
          r_state <= WAIT_LOW;
        end

        // Wait for the input to be low so the first rise seen starts a full
        // high phase; a measurement never begins part-way through a pulse.
        WAIT_LOW: begin
          if (!w_s) begin
            r_state <= WAIT_RISE;
            r_cnt   <= w_cnt_inc;
          end else if (w_cnt_max) begin
            r_state       <= STUCK;
            r_no_signal   <= 1'b1;
            r_stuck_level <= w_s;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        WAIT_RISE: begin
          if (w_rise) begin
            r_state <= HIGH;
            r_cnt   <= CNT_ONE;
          end else if (w_cnt_max) begin
            r_state       <= STUCK;
            r_no_signal   <= 1'b1;
            r_stuck_level <= w_s;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        // The count runs across both phases; the value at the fall is the
        // high time and the value at the next rise is the whole period.
        HIGH: begin
          if (w_fall) begin
            r_hi    <= r_cnt;
            r_state <= LOW;
            r_cnt   <= w_cnt_inc;
          end else if (w_cnt_max) begin
            r_state       <= STUCK;
            r_no_signal   <= 1'b1;
            r_stuck_level <= w_s;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        LOW: begin
          if (w_rise) begin
            r_period    <= r_cnt;
            r_high_time <= r_hi;
            r_valid     <= 1'b1;
            r_cnt       <= CNT_ONE;
            r_state     <= HIGH;
          end else if (w_cnt_max) begin
            r_state       <= STUCK;
            r_no_signal   <= 1'b1;
            r_stuck_level <= w_s;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        // Counter frozen; a rise starts a fresh high phase with no report.
        STUCK: begin
          if (w_rise) begin
            r_state     <= HIGH;
            r_cnt       <= CNT_ONE;
            r_no_signal <= 1'b0;
          end
        end

        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule
